// File: rtl/kim_fetch_ctrl.sv
// kim_fetch_ctrl
//
// Instruction-fetch controller. It sits between an external PC register, a
// single-outstanding instruction memory port and the IF/ID pipeline register.
//
// Ports
//   clk, rstn              clock (rising edge), asynchronous active-low reset
//   pc                     current PC register value
//   pc_stall, pc_next      PC register hold / next value (loaded when pc_stall=0)
//   br_taken, br_target    redirect request and address from EX
//   id_stall               decode cannot accept; IF/ID holds
//   imem_req, imem_addr    fetch request and address
//   imem_ack, imem_rdata   single-cycle data-valid pulse and fetched word
//   if_valid/instr/pc      IF/ID register contents
//   flush_if               high in every cycle a redirect is accepted
//
// States
//   BOOT  one idle cycle after reset
//   REQ   fetch at pc outstanding
//   HOLD  fetched word parked in a side buffer while decode is stalled
//   DROP  fetch at drop_addr still outstanding but its data is to be discarded
module kim_fetch_ctrl #(
  parameter int PC_ADDR_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [PC_ADDR_WIDTH-1:0] pc,
  output logic                     pc_stall,
  output logic [PC_ADDR_WIDTH-1:0] pc_next,
  input  logic                     br_taken,
  input  logic [PC_ADDR_WIDTH-1:0] br_target,
  input  logic                     id_stall,
  output logic                     imem_req,
  output logic [PC_ADDR_WIDTH-1:0] imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_rdata,
  output logic                     if_valid,
  output logic [31:0]              if_instr,
  output logic [PC_ADDR_WIDTH-1:0] if_pc,
  output logic                     flush_if
);

  localparam int W = PC_ADDR_WIDTH;

  typedef enum logic [1:0] {BOOT, REQ, HOLD, DROP} state_e;

  state_e         state_q, state_d;
  logic           if_valid_q, if_valid_d;
  logic [31:0]    if_instr_q, if_instr_d;
  logic [W-1:0]   if_pc_q, if_pc_d;
  logic [31:0]    buf_instr_q, buf_instr_d;
  logic [W-1:0]   buf_pc_q, buf_pc_d;
  logic [W-1:0]   drop_addr_q, drop_addr_d;

  // The PC adder wraps naturally at 2^W.
  assign pc_next = br_taken ? br_target : pc + W'(4);

  // The memory port is driven straight from state so request and address
  // cannot move until the state leaves REQ/DROP, which only happens on ack
  // (or a redirect in REQ that parks the old address in drop_addr).
  assign imem_req  = (state_q == REQ) || (state_q == DROP);
  assign imem_addr = (state_q == DROP) ? drop_addr_q : pc;

  assign if_valid = if_valid_q;
  assign if_instr = if_instr_q;
  assign if_pc    = if_pc_q;

  // pc_stall and flush_if must react to ack/redirect in the same cycle, so
  // they are decoded combinationally from state and inputs.
  always_comb begin
    state_d     = state_q;
    if_valid_d  = if_valid_q;
    if_instr_d  = if_instr_q;
    if_pc_d     = if_pc_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    drop_addr_d = drop_addr_q;
    pc_stall    = 1'b1;
    flush_if    = 1'b0;
    unique case (state_q)
      BOOT: state_d = REQ;
      REQ: begin
        if (br_taken) begin
          pc_stall   = 1'b0;
          flush_if   = 1'b1;
          if_valid_d = 1'b0;
          // An ack in the same cycle retires the stale fetch on the spot;
          // otherwise it is still in flight and must be drained first.
          if (!imem_ack) begin
            drop_addr_d = pc;
            state_d     = DROP;
          end
        end else if (imem_ack && !id_stall) begin
          if_instr_d = imem_rdata;
          if_pc_d    = pc;
          if_valid_d = 1'b1;
          pc_stall   = 1'b0;
        end else if (imem_ack) begin
          buf_instr_d = imem_rdata;
          buf_pc_d    = pc;
          state_d     = HOLD;
        end else if (!id_stall) begin
          if_valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (br_taken) begin
          pc_stall   = 1'b0;
          flush_if   = 1'b1;
          if_valid_d = 1'b0;
          state_d    = REQ;
        end else if (!id_stall) begin
          if_instr_d = buf_instr_q;
          if_pc_d    = buf_pc_q;
          if_valid_d = 1'b1;
          pc_stall   = 1'b0;
          state_d    = REQ;
        end
      end
      DROP: begin
        if (br_taken) begin
          pc_stall   = 1'b0;
          flush_if   = 1'b1;
          if_valid_d = 1'b0;
        end
        if (!id_stall) if_valid_d = 1'b0;
        if (imem_ack) state_d = REQ;
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= BOOT;
      if_valid_q  <= 1'b0;
      if_instr_q  <= '0;
      if_pc_q     <= '0;
      buf_instr_q <= '0;
      buf_pc_q    <= '0;
      drop_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      if_valid_q  <= if_valid_d;
      if_instr_q  <= if_instr_d;
      if_pc_q     <= if_pc_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      drop_addr_q <= drop_addr_d;
    end
  end

endmodule
